// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry
// resolves one result bit per clock, LSB first, under a start/done handshake.
module serial_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    // Handshake: start is sampled only while IDLE; done pulses for one cycle
    // and result/flags stay valid from then until the next accepted start.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;

    always_comb begin
        s_bit    = opa[0] ^ opb[0] ^ carry;
        c_bit    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered decodes of the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == FIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Subtraction is a + ~b + 1, the +1 entering as initial carry.
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa    <= opa >> 1;
                    opb    <= opb >> 1;
                    result <= {s_bit, result[WIDTH-1:1]};
                    carry  <= c_bit;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        cout     <= c_bit;
                        overflow <= carry ^ c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized scoreboard bench for serial_addsub: driver pushes expected
// results from an arithmetic reference model, a negedge monitor pops on done.
module tb_serial_addsub;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W+2:0] exp_q[$];
    int           lat_q[$];
    int           done_log[$];
    int           errors = 0;
    int           checks = 0;
    int           done_cnt = 0;
    int           busy_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: plain integer arithmetic, packed as {result,cout,overflow,zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic msub);
        longint       sa, sb, exact, smax, smin;
        longint       ua, ub;
        logic [W-1:0] r;
        logic         c, v;
        sa    = longint'($signed(ma));
        sb    = longint'($signed(mb));
        ua    = longint'({32'd0, ma});
        ub    = longint'({32'd0, mb});
        smax  = (longint'(1) <<< (W - 1)) - 1;
        smin  = -(longint'(1) <<< (W - 1));
        exact = msub ? (sa - sb) : (sa + sb);
        v     = (exact > smax) || (exact < smin);
        r     = msub ? (ma - mb) : (ma + mb);
        c     = msub ? (ua >= ub) : ((ua + ub) >= (longint'(1) <<< W));
        return {r, c, v, (r == '0)};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [W+2:0] e;
        int           l;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (done) begin
                    done_cnt++;
                    done_log.push_back(cyc);
                    check("busy_low_at_done", 64'(busy), 64'd0);
                    check("busy_length", 64'(busy_run), 64'(W));
                    busy_run = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        l = lat_q.pop_front();
                        check("result_flags", 64'({result, cout, overflow, zero}), 64'(e));
                        check("latency", 64'(cyc - l), 64'(W));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
        @(negedge clk);
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        exp_q.push_back(model(ia, ib, isub));
        @(posedge clk);
        #1;
        lat_q.push_back(cyc);
        check("accepted", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < W + 10 && done_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 10);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
        issue(ia, ib, isub);
        wait_done();
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W - 1) {1'b0}}};
            3:       return {1'b0, {(W - 1) {1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_outputs", 64'({result, cout, overflow, zero}), 64'({{W{1'b0}}, 3'b001}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed arithmetic corners
        run_op(32'd5, 32'd3, 1'b0);
        run_op(32'd5, 32'd5, 1'b1);
        run_op(32'd0, 32'd1, 1'b1);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b1);

        // start during RUN must be ignored
        issue(32'd1, 32'd2, 1'b0);
        repeat (5) @(negedge clk);
        a     = 32'd100;
        b     = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        #1;
        check("idle_after_ignored_start", 64'(busy), 64'd0);
        check("no_extra_done", 64'(done_cnt - d0), 64'd0);
        check("result_held", 64'({result, cout, overflow, zero}), 64'({32'd3, 3'b000}));

        // start held high: back-to-back operations
        @(negedge clk);
        a     = 32'd1;
        b     = 32'd2;
        sub   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(32'd1, 32'd2, 1'b0));
        exp_q.push_back(model(32'd1, 32'd2, 1'b0));
        @(posedge clk);
        #1;
        lat_q.push_back(cyc);
        lat_q.push_back(cyc + W + 2);
        check("held_first_accept", 64'(busy), 64'd1);
        wait_done();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_second_accept", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        if (done_log.size() >= 2)
            check("back_to_back_spacing",
                  64'(done_log[done_log.size() - 1] - done_log[done_log.size() - 2]), 64'(W + 2));

        // reset mid-RUN aborts the operation
        issue(32'h1234_5678, 32'd1, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_outputs", 64'({result, cout, overflow, zero}), 64'({{W{1'b0}}, 3'b001}));
        exp_q.delete();
        lat_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        run_op(32'h1234_5678, 32'd1, 1'b0);

        // randomized operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor for the single-cycle MIPS datapath's multi-cycle arithmetic path. It accepts two WIDTH-bit operands and an add/subtract select through a start/done handshake. It resolves one result bit per clock, LSB first, through a single full-adder slice with a registered carry. It reports the result with carry-out, signed-overflow and zero flags, and is the sequential counterpart of the combinational full-adder ALU slice.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being computed (RUN)
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

## Operation
- The FSM has three states: IDLE, RUN and DONE. It encodes a bit counter cnt of width clog2(WIDTH)+1.
- IDLE with start=1 loads the working registers and goes to RUN, cnt=0:
  - opa=a
  - opb = sub ? ~b : b
  - carry=sub
  - The result shift register is not cleared here.
- start in RUN or DONE is ignored. Operands changing after acceptance have no effect.
- Each RUN cycle processes one bit:
  - s = opa[0]^opb[0]^carry
  - c' = majority(opa[0],opb[0],carry)
  - opa and opb shift right by 1.
  - The result shifts right with s inserted at bit WIDTH−1.
  - carry ← c', cnt ← cnt+1.
- On the cycle processing cnt==WIDTH−1 (the MSB):
  - Record msb_cin = carry before update.
  - Register cout = c' and overflow = msb_cin ^ c'.
  - Transition to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
- result, cout, overflow and zero hold their values from DONE until the next accepted start. They are then undefined-but-stable-in-shift during RUN; the verifier checks them only at done and after.
- zero is computed combinationally from the result register, qualified as above.
- Arithmetic is modulo 2^WIDTH. b = 0 with sub=1 gives cout=1.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by system) forces:
  - state=IDLE, cnt=0, carry=0
  - opa=opb=result=0
  - busy=0, done=0, cout=0, overflow=0
  - zero therefore =1
- Reset mid-RUN aborts the operation: no done is issued and the outputs show the reset values.
- Start accepted at edge E0 gives the following cycle-level sequence:
  - busy=1 from E0 through E_WIDTH.
  - MSB is processed in the cycle ending at edge E_WIDTH.
  - done=1 from E_WIDTH to E_WIDTH+1.
  - Latency from start edge to done: WIDTH edges, i.e. 32 cycles at default. Throughput is one operation per WIDTH+2 cycles.
- busy and done are never high simultaneously.
- The earliest next start is sampled at edge E_WIDTH+2. This is the first IDLE cycle after done.
- start held high continuously launches back-to-back operations: one every WIDTH+2 cycles.
- All outputs are registered except zero.

## Test plan
- a=5, b=3, sub=0 → done exactly 32 cycles after the start edge; result=8, cout=0, overflow=0, zero=0; busy high for 32 cycles.
- a=5, b=5, sub=1 → result=0, zero=1, cout=1, overflow=0. Then a=0, b=1, sub=1 → result=0xFFFFFFFF, cout=0, overflow=0.
- a=0x7FFFFFFF, b=1, sub=0 → result=0x80000000, overflow=1, cout=0. Then a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, overflow=1, cout=1.
- a=0xFFFFFFFF, b=1, sub=0 → result=0, cout=1, zero=1, overflow=0.
- Protocol checks, using a=1, b=2, sub=0:
  - During RUN, pulse start with a=100, b=100 → ignored; done gives result=3.
  - start held high → second done exactly 34 cycles after the first.
- Assert rst_n=0 after 10 RUN cycles of a=0x12345678, b=1 → immediately busy=0, result=0, zero=1; no done for 40 cycles. A fresh operation afterwards gives result=0x12345679.
